// File: rtl/imm_gen_pipe_if.sv
// Handshake bundle between the decode-side producer and the immediate generator.
// master drives instructions and out_ready; slave is the generator.
interface imm_gen_pipe_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_instr;
    logic [2:0]       in_imm_src;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_imm;
    logic [TAG_W-1:0] out_tag;
    logic             out_illegal;

    modport master (
        output in_valid, in_instr, in_imm_src, in_tag, out_ready,
        input  in_ready, out_valid, out_imm, out_tag, out_illegal
    );

    modport slave (
        input  in_valid, in_instr, in_imm_src, in_tag, out_ready,
        output in_ready, out_valid, out_imm, out_tag, out_illegal
    );
endinterface

// File: rtl/imm_gen_pipe.sv
// RISC-V immediate generator; 1-cycle latency from in-transfer to out_valid.
// Backpressure: 2-entry skid buffer, in_ready registered (low only when both entries full).
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    imm_gen_pipe_if.slave bus
);

    generate
        if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
            $error("imm_gen_pipe: XLEN must be 32 or 64");
        end
    endgenerate

    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_e;

    typedef struct packed {
        logic [XLEN-1:0]  imm;
        logic [TAG_W-1:0] tag;
        logic             illegal;
    } entry_t;

    state_e      state_q, state_d;
    entry_t      head_q, head_d;
    entry_t      tail_q, tail_d;
    entry_t      new_entry;
    logic        in_ready_q, in_ready_d;
    logic        in_xfer, out_xfer;
    logic [31:0] instr;
    logic        unused_instr;

    assign instr        = bus.in_instr;
    assign unused_instr = ^instr[6:0];

    assign in_xfer  = bus.in_valid && in_ready_q;
    assign out_xfer = (state_q != EMPTY) && bus.out_ready;

    // Size casts of signed operands sign-extend to XLEN; unsigned ones zero-extend.
    always_comb begin
        new_entry     = '0;
        new_entry.tag = bus.in_tag;
        case (bus.in_imm_src)
            3'b000: new_entry.imm = XLEN'($signed(instr[31:20]));
            3'b001: new_entry.imm = XLEN'($signed({instr[31:25], instr[11:7]}));
            3'b010: new_entry.imm = XLEN'($signed({instr[31], instr[7], instr[30:25],
                                                   instr[11:8], 1'b0}));
            3'b011: new_entry.imm = XLEN'($signed({instr[31:12], 12'b0}));
            3'b100: new_entry.imm = XLEN'($signed({instr[31], instr[19:12], instr[20],
                                                   instr[30:21], 1'b0}));
            3'b101: new_entry.imm = XLEN'(instr[19:15]);
            3'b110: new_entry.imm = (XLEN == 64) ? XLEN'(instr[25:20]) : XLEN'(instr[24:20]);
            default: begin
                new_entry.imm     = '0;
                new_entry.illegal = 1'b1;
            end
        endcase
    end

    // head is always the oldest entry and drives the outputs directly.
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_xfer) begin
                        head_d  = new_entry;
                        state_d = ONE;
                    end
                end
                ONE: begin
                    if (in_xfer && out_xfer) begin
                        head_d = new_entry;
                    end else if (in_xfer) begin
                        tail_d  = new_entry;
                        state_d = TWO;
                    end else if (out_xfer) begin
                        state_d = EMPTY;
                    end
                end
                TWO: begin
                    if (out_xfer) begin
                        head_d  = tail_q;
                        state_d = ONE;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
        in_ready_d = (state_d != TWO);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= EMPTY;
            head_q     <= '0;
            tail_q     <= '0;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign bus.in_ready    = in_ready_q;
    assign bus.out_valid   = (state_q != EMPTY);
    assign bus.out_imm     = head_q.imm;
    assign bus.out_tag     = head_q.tag;
    assign bus.out_illegal = head_q.illegal;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench for imm_gen_pipe: XLEN=32 and XLEN=64 instances, directed vectors.
module tb_imm_gen_pipe;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    imm_gen_pipe_if #(.XLEN(32), .TAG_W(5)) b32 ();
    imm_gen_pipe_if #(.XLEN(64), .TAG_W(5)) b64 ();

    imm_gen_pipe #(.XLEN(32), .TAG_W(5)) dut32 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .bus(b32.slave)
    );
    imm_gen_pipe #(.XLEN(64), .TAG_W(5)) dut64 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .bus(b64.slave)
    );

    typedef struct {
        logic [63:0] imm;
        logic [4:0]  tag;
        logic        ill;
    } exp_t;

    exp_t q32[$];
    exp_t q64[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitors compare the head of each scoreboard whenever an output is presented.
    always @(negedge clk) begin
        if (rst_n && b32.out_valid) begin
            if (q32.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL out32_unexpected: got tag %0d, expected no output", b32.out_tag);
            end else begin
                check("out32_imm", {32'b0, b32.out_imm}, q32[0].imm);
                check("out32_tag", 64'(b32.out_tag), 64'(q32[0].tag));
                check("out32_ill", 64'(b32.out_illegal), 64'(q32[0].ill));
                if (b32.out_ready) void'(q32.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && b64.out_valid) begin
            if (q64.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL out64_unexpected: got tag %0d, expected no output", b64.out_tag);
            end else begin
                check("out64_imm", b64.out_imm, q64[0].imm);
                check("out64_tag", 64'(b64.out_tag), 64'(q64[0].tag));
                check("out64_ill", 64'(b64.out_illegal), 64'(q64[0].ill));
                if (b64.out_ready) void'(q64.pop_front());
            end
        end
    end

    task automatic send32(input logic [31:0] instr, input logic [2:0] src, input logic [4:0] tag,
                          input logic [31:0] eimm, input logic eill);
        int n = 0;
        b32.in_valid   = 1'b1;
        b32.in_instr   = instr;
        b32.in_imm_src = src;
        b32.in_tag     = tag;
        @(negedge clk);
        while (!b32.in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!b32.in_ready) begin
            n_chk++;
            n_fail++;
            $display("FAIL send32_timeout: tag %0d in_ready got 0, expected 1", tag);
        end else begin
            q32.push_back('{{32'b0, eimm}, tag, eill});
        end
        @(posedge clk);
        #1;
        b32.in_valid = 1'b0;
    endtask

    task automatic send64(input logic [31:0] instr, input logic [2:0] src, input logic [4:0] tag,
                          input logic [63:0] eimm, input logic eill);
        int n = 0;
        b64.in_valid   = 1'b1;
        b64.in_instr   = instr;
        b64.in_imm_src = src;
        b64.in_tag     = tag;
        @(negedge clk);
        while (!b64.in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!b64.in_ready) begin
            n_chk++;
            n_fail++;
            $display("FAIL send64_timeout: tag %0d in_ready got 0, expected 1", tag);
        end else begin
            q64.push_back('{eimm, tag, eill});
        end
        @(posedge clk);
        #1;
        b64.in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        b32.in_valid = 1'b0; b32.in_instr = '0; b32.in_imm_src = '0; b32.in_tag = '0;
        b32.out_ready = 1'b1;
        b64.in_valid = 1'b0; b64.in_instr = '0; b64.in_imm_src = '0; b64.in_tag = '0;
        b64.out_ready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        #2;
        check("rst_out_valid", 64'(b32.out_valid), 64'd0);
        check("rst_out_imm", {32'b0, b32.out_imm}, 64'd0);
        check("rst_out_tag", 64'(b32.out_tag), 64'd0);
        check("rst_out_ill", 64'(b32.out_illegal), 64'd0);
        check("rst_in_ready", 64'(b32.in_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Formats, XLEN=32, streaming with out_ready=1
        send32(32'hFFF00093, 3'b000, 5'd1, 32'hFFFFFFFF, 1'b0);
        check("lat1_out_valid", 64'(b32.out_valid), 64'd1);
        check("lat1_out_imm", {32'b0, b32.out_imm}, 64'hFFFFFFFF);
        send32(32'hFE000EE3, 3'b010, 5'd2, 32'hFFFFFFFC, 1'b0);
        send32(32'h800000B7, 3'b011, 5'd3, 32'h80000000, 1'b0);
        send32(32'h340FD073, 3'b101, 5'd4, 32'h0000001F, 1'b0);
        send32(32'h340FD073, 3'b111, 5'd5, 32'h00000000, 1'b1);
        send32(32'hFE20AC23, 3'b001, 5'd6, 32'hFFFFFFF8, 1'b0);
        send32(32'h001000EF, 3'b100, 5'd7, 32'h00000800, 1'b0);
        send32(32'h03F09093, 3'b110, 5'd8, 32'h0000001F, 1'b0);
        send32(32'h7FF00093, 3'b000, 5'd9, 32'h000007FF, 1'b0);

        // Formats, XLEN=64
        send64(32'h800000B7, 3'b011, 5'd10, 64'hFFFFFFFF80000000, 1'b0);
        send64(32'h03F09093, 3'b110, 5'd11, 64'h000000000000003F, 1'b0);
        send64(32'hFFF00093, 3'b000, 5'd12, 64'hFFFFFFFFFFFFFFFF, 1'b0);
        send64(32'h12345677, 3'b111, 5'd13, 64'h0, 1'b1);

        // Backpressure: fill both entries, hold, then drain in order
        b32.out_ready = 1'b0;
        fork
            begin
                send32(32'h00100093, 3'b000, 5'd1, 32'h1, 1'b0);
                send32(32'h00200093, 3'b000, 5'd2, 32'h2, 1'b0);
                send32(32'h00300093, 3'b000, 5'd3, 32'h3, 1'b0);
                send32(32'h00400093, 3'b000, 5'd4, 32'h4, 1'b0);
            end
            begin
                repeat (4) @(negedge clk);
                check("full_in_ready", 64'(b32.in_ready), 64'd0);
                check("full_hold_tag", 64'(b32.out_tag), 64'd1);
                @(posedge clk);
                #1;
                b32.out_ready = 1'b1;
            end
        join
        n = 0;
        while (q32.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("drain_left", 64'(q32.size()), 64'd0);

        // Flush while full with a concurrent input
        @(posedge clk);
        #1;
        b32.out_ready = 1'b0;
        send32(32'h00500093, 3'b000, 5'd5, 32'h5, 1'b0);
        send32(32'h00600093, 3'b000, 5'd6, 32'h6, 1'b0);
        b32.in_valid = 1'b1; b32.in_instr = 32'h00700093; b32.in_imm_src = 3'b000; b32.in_tag = 5'd7;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        b32.in_valid = 1'b0;
        q32.delete();
        @(negedge clk);
        check("flush_out_valid", 64'(b32.out_valid), 64'd0);
        check("flush_in_ready", 64'(b32.in_ready), 64'd1);
        b32.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("flush_no_tag7", 64'(b32.out_valid), 64'd0);

        // Asynchronous reset mid-stream
        @(posedge clk);
        #1;
        b32.out_ready = 1'b0;
        send32(32'h00800093, 3'b000, 5'd8, 32'h8, 1'b0);
        send32(32'hFFF00093, 3'b000, 5'd9, 32'hFFFFFFFF, 1'b0);
        #3;
        rst_n = 1'b0;
        #2;
        check("arst_out_valid", 64'(b32.out_valid), 64'd0);
        check("arst_out_imm", {32'b0, b32.out_imm}, 64'd0);
        check("arst_out_tag", 64'(b32.out_tag), 64'd0);
        check("arst_in_ready", 64'(b32.in_ready), 64'd1);
        q32.delete();
        @(negedge clk);
        rst_n = 1'b1;
        b32.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("arst_no_replay", 64'(b32.out_valid), 64'd0);
        send32(32'h01400093, 3'b000, 5'd20, 32'h14, 1'b0);

        @(posedge clk);
        n = 0;
        while ((q32.size() != 0 || q64.size() != 0) && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("final_q32_left", 64'(q32.size()), 64'd0);
        check("final_q64_left", 64'(q64.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
